// File: rtl/bshift_seq_ctrl.sv
// Sequencer that drives a shared 4-bit barrel shifter in passes of at most
// STEP, feeding each result back, and returns the final word on rsp_*.
// Ports:
//   clk, rstn (async, active low), flush (sync abort)
//   req_valid/req_ready/req_data/req_amt : request channel
//   sh_a/sh_n -> shifter, sh_o <- shifter (combinational)
//   rsp_valid/rsp_ready/rsp_data/rsp_passes : response channel
module bshift_seq_ctrl #(
  parameter int DW    = 4,
  parameter int AMT_W = 4,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DW-1:0]    req_data,
  input  logic [AMT_W-1:0] req_amt,
  output logic [DW-1:0]    sh_a,
  output logic [1:0]       sh_n,
  input  logic [DW-1:0]    sh_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [2:0]       rsp_passes
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    dreg_q, dreg_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [AMT_W-1:0] step_w;
  logic             last_pass;

  // Pass amount: min(rem, STEP) while shifting, zero otherwise.
  always_comb begin
    step_w = '0;
    if (state_q == SHIFT) begin
      if (rem_q > AMT_W'(STEP)) step_w = AMT_W'(STEP);
      else                      step_w = rem_q;
    end
  end

  assign last_pass = (rem_q <= AMT_W'(STEP));

  always_comb begin
    state_d = state_q;
    dreg_d  = dreg_q;
    rem_d   = rem_q;
    pcnt_d  = pcnt_q;
    if (flush) begin
      state_d = IDLE;
      dreg_d  = '0;
      rem_d   = '0;
      pcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            dreg_d  = req_data;
            rem_d   = req_amt;
            pcnt_d  = '0;
            state_d = (req_amt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          dreg_d = sh_o;
          rem_d  = rem_q - step_w;
          pcnt_d = pcnt_q + 3'd1;
          if (last_pass) state_d = DONE;
        end
        DONE: begin
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      dreg_q  <= '0;
      rem_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dreg_q  <= dreg_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_data   = dreg_q;
  assign rsp_passes = pcnt_q;
  assign sh_a       = dreg_q;
  assign sh_n       = step_w[1:0];

endmodule

// File: tb/tb_bshift_seq_ctrl.sv
// Scoreboard bench for bshift_seq_ctrl with a rotate-left shifter model.
// Stimulus pushes expected passes/responses; a negedge monitor pops them.
module tb_bshift_seq_ctrl;

  logic       clk = 0;
  logic       rstn;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_data;
  logic [3:0] req_amt;
  logic [3:0] sh_a;
  logic [1:0] sh_n;
  logic [3:0] sh_o;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_passes;

  int checks = 0;
  int errors = 0;

  logic [6:0] rsp_q[$];
  logic [1:0] shn_q[$];

  always #5 clk = ~clk;

  bshift_seq_ctrl dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt),
    .sh_a(sh_a), .sh_n(sh_n), .sh_o(sh_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_passes(rsp_passes)
  );

  function automatic logic [3:0] rotl(input logic [3:0] a,
                                      input logic [1:0] n);
    logic [7:0] t;
    t = {a, a} << n;
    return t[7:4];
  endfunction

  assign sh_o = rotl(sh_a, sh_n);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare shifter passes and responses against the queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (sh_n != 2'd0) begin
        if (shn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sh_n_unexpected: got %0d expected none", sh_n);
        end else begin
          chk("sh_n", sh_n, shn_q.pop_front());
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got %b expected none", rsp_data);
        end else begin
          logic [6:0] e;
          e = rsp_q.pop_front();
          chk("rsp_data", rsp_data, e[6:3]);
          chk("rsp_passes", rsp_passes, e[2:0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [3:0] a);
    int n;
    req_valid = 1;
    req_data  = d;
    req_amt   = a;
    n = 0;
    while (!req_ready && n < 50) begin
      cyc(1);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    cyc(1);
    req_valid = 0;
  endtask

  // Edges counted from (and including) the accept edge.
  task automatic wait_rsp(input int exp_edges);
    int cnt;
    cnt = 1;
    while (!rsp_valid && cnt < 20) begin
      cyc(1);
      cnt++;
    end
    chk("latency", cnt, exp_edges);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_passes"}, rsp_passes, 0);
    chk({tag, "_sh_a"}, sh_a, 0);
    chk({tag, "_sh_n"}, sh_n, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 0; flush = 0; req_valid = 0;
    req_data = 0; req_amt = 0; rsp_ready = 1;
    cyc(2);
    chk_reset_outs("rst0");
    rstn = 1;
    cyc(1);

    // 1) 1010 rotl 5 -> 0101, passes 3,2
    shn_q.push_back(2'd3); shn_q.push_back(2'd2);
    rsp_q.push_back({4'b0101, 3'd2});
    send(4'b1010, 4'd5);
    wait_rsp(3);
    cyc(2);

    // 2) 1101 rotl 15 -> 1110, five passes of 3
    repeat (5) shn_q.push_back(2'd3);
    rsp_q.push_back({4'b1110, 3'd5});
    send(4'b1101, 4'd15);
    wait_rsp(6);
    cyc(2);

    // 3) amt 0 -> no pass
    rsp_q.push_back({4'b0001, 3'd0});
    send(4'b0001, 4'd0);
    wait_rsp(1);
    cyc(2);

    // 4) backpressure on response
    rsp_ready = 0;
    shn_q.push_back(2'd3); shn_q.push_back(2'd1);
    rsp_q.push_back({4'b0011, 3'd2});
    send(4'b0011, 4'd4);
    wait_rsp(3);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 4'b0011);
      chk("hold_sh_a", sh_a, 4'b0011);
      chk("hold_req_ready", req_ready, 0);
      cyc(1);
    end
    rsp_ready = 1;
    cyc(1);
    chk("post_rsp_idle", req_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    cyc(1);

    // 5) async reset during 2nd pass
    shn_q.push_back(2'd3); shn_q.push_back(2'd3);
    send(4'b1000, 4'd9);
    cyc(1);
    @(negedge clk);
    #1;
    rstn = 0;
    #1;
    chk_reset_outs("rst_mid");
    cyc(1);
    rstn = 1;
    cyc(1);
    shn_q.push_back(2'd1);
    rsp_q.push_back({4'b1100, 3'd1});
    send(4'b0110, 4'd1);
    wait_rsp(2);
    cyc(2);

    // 6a) flush during SHIFT
    shn_q.push_back(2'd3);
    send(4'b0101, 4'd12);
    flush = 1;
    cyc(1);
    flush = 0;
    chk("flush_idle", req_ready, 1);
    chk("flush_no_rsp", rsp_valid, 0);
    chk("flush_sh_a", sh_a, 0);
    cyc(4);
    chk("flush_still_idle", rsp_valid, 0);

    // 6b) flush beats a request in IDLE
    flush = 1;
    req_valid = 1;
    req_data = 4'b1111;
    req_amt = 4'd2;
    cyc(1);
    flush = 0;
    req_valid = 0;
    chk("flush_req_ready", req_ready, 1);
    chk("flush_req_sh_a", sh_a, 0);
    chk("flush_req_sh_n", sh_n, 0);
    cyc(4);
    chk("flush_req_no_rsp", rsp_valid, 0);

    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("shn_q_empty", shn_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
